// File: rtl/word_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: takes WIDTH-bit words
// over valid/ready and emits one bit per clock on D_out, with optional idle gaps.
module word_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             abort,
   output logic             D_out,
   output logic             bit_valid,
   output logic             last_bit,
   output logic             busy,
   output logic [7:0]       words_sent,
   output logic [1:0]       fsm_state
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT    = 2'd1;
   localparam logic [1:0] GAP_WAIT = 2'd2;

   localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam bit         NO_GAP   = (GAP == 0);

   // Handshake: a word transfers on a rising edge where word_valid and
   // word_ready are both 1; word_in must stay stable while valid waits on ready.
   logic [1:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [4:0]       bit_cnt;
   logic [3:0]       gap_cnt;
   logic             last_cycle;
   logic             accept;
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] shift_val;

   assign last_cycle = (state == SHIFT) && (bit_cnt == 5'd0);
   assign word_ready = rst && !abort &&
                       ((state == IDLE) || (last_cycle && NO_GAP));
   assign accept     = word_valid && word_ready;

   // D_out holds the current bit; shreg holds only the bits still to come.
   assign first_bit = MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
   assign next_bit  = MSB_FIRST ? shreg[WIDTH-1]   : shreg[0];
   assign load_val  = MSB_FIRST ? (word_in << 1)   : (word_in >> 1);
   assign shift_val = MSB_FIRST ? (shreg << 1)     : (shreg >> 1);

   assign busy      = (state != IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= 5'd0;
         gap_cnt    <= 4'd0;
         D_out      <= 1'b0;
         bit_valid  <= 1'b0;
         last_bit   <= 1'b0;
         words_sent <= 8'd0;
      end else if (abort) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= 5'd0;
         gap_cnt   <= 4'd0;
         D_out     <= 1'b0;
         bit_valid <= 1'b0;
         last_bit  <= 1'b0;
      end else if (accept) begin
         // Also covers the seamless reload on the final bit when GAP is 0.
         if (last_cycle) words_sent <= words_sent + 8'd1;
         state     <= SHIFT;
         shreg     <= load_val;
         bit_cnt   <= LAST_CNT;
         D_out     <= first_bit;
         bit_valid <= 1'b1;
         last_bit  <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               if (bit_cnt == 5'd0) begin
                  words_sent <= words_sent + 8'd1;
                  shreg      <= '0;
                  D_out      <= 1'b0;
                  bit_valid  <= 1'b0;
                  last_bit   <= 1'b0;
                  if (NO_GAP) begin
                     state <= IDLE;
                  end else begin
                     state   <= GAP_WAIT;
                     gap_cnt <= GAP_LOAD;
                  end
               end else begin
                  D_out    <= next_bit;
                  shreg    <= shift_val;
                  bit_cnt  <= bit_cnt - 5'd1;
                  last_bit <= (bit_cnt == 5'd1);
               end
            end
            GAP_WAIT: begin
               if (gap_cnt == 4'd0) state <= IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances (MSB/GAP=0, MSB/GAP=2,
// LSB/GAP=0) share one stimulus stream; each step checks the relevant instance.
module tb_word_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] word_in;
   logic       word_valid;
   logic       abort;

   logic       ready_a, d_a, bv_a, lb_a, busy_a;
   logic [7:0] ws_a;
   logic [1:0] st_a;
   logic       ready_b, d_b, bv_b, lb_b, busy_b;
   logic [7:0] ws_b;
   logic [1:0] st_b;
   logic       ready_c, d_c, bv_c, lb_c, busy_c;
   logic [7:0] ws_c;
   logic [1:0] st_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   word_serializer u_a (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(ready_a), .abort(abort), .D_out(d_a), .bit_valid(bv_a),
      .last_bit(lb_a), .busy(busy_a), .words_sent(ws_a), .fsm_state(st_a)
   );

   word_serializer #(.GAP(2)) u_b (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(ready_b), .abort(abort), .D_out(d_b), .bit_valid(bv_b),
      .last_bit(lb_b), .busy(busy_b), .words_sent(ws_b), .fsm_state(st_b)
   );

   word_serializer #(.MSB_FIRST(1'b0)) u_c (
      .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
      .word_ready(ready_c), .abort(abort), .D_out(d_c), .bit_valid(bv_c),
      .last_bit(lb_c), .busy(busy_c), .words_sent(ws_c), .fsm_state(st_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst        = 1'b0;
      word_valid = 1'b0;
      abort      = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0]  exp_w;
      logic [15:0] exp16;
      int          n;
      int          budget;

      rst        = 1'b0;
      word_in    = 8'h00;
      word_valid = 1'b0;
      abort      = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_d_out", d_a, 0);
      check("rst_bit_valid", bv_a, 0);
      check("rst_last_bit", lb_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_words_sent", ws_a, 0);
      check("rst_ready_a", ready_a, 0);
      check("rst_ready_b", ready_b, 0);
      rst = 1'b1;
      #1 check("idle_ready", ready_a, 1);

      // Single word 8'hA5, MSB first
      exp_w      = 8'hA5;
      word_in    = exp_w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("a5_d_out", d_a, exp_w[7-i]);
         check("a5_bit_valid", bv_a, 1);
         check("a5_last_bit", lb_a, (i == 7) ? 1 : 0);
         tick();
      end
      check("a5_after_bv", bv_a, 0);
      check("a5_after_d", d_a, 0);
      check("a5_words_sent", ws_a, 1);
      check("a5_idle", busy_a, 0);

      // Back-to-back A5, 3C with GAP=0
      do_reset();
      exp16      = 16'hA53C;
      word_in    = 8'hA5;
      word_valid = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         check("b2b_d_out", d_a, exp16[15-i]);
         check("b2b_bit_valid", bv_a, 1);
         if (i == 3) check("b2b_ready_mid", ready_a, 0);
         if (i == 7) begin
            check("b2b_ready_last", ready_a, 1);
            check("b2b_last_bit", lb_a, 1);
            word_in = 8'h3C;
         end
         if (i == 8) word_valid = 1'b0;
         tick();
      end
      check("b2b_words_sent", ws_a, 2);
      check("b2b_after_bv", bv_a, 0);

      // GAP=2 instance: FF, gap, idle accept, 01
      do_reset();
      word_in    = 8'hFF;
      word_valid = 1'b1;
      tick();
      word_in = 8'h01;
      for (int i = 0; i < 8; i++) begin
         check("gap_ff_d", d_b, 1);
         check("gap_ff_bv", bv_b, 1);
         check("gap_ff_busy", busy_b, 1);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         check("gap_wait_d", d_b, 0);
         check("gap_wait_bv", bv_b, 0);
         check("gap_wait_busy", busy_b, 1);
         check("gap_wait_ready", ready_b, 0);
         tick();
      end
      check("gap_idle_busy", busy_b, 0);
      check("gap_idle_ready", ready_b, 1);
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("gap_01_d", d_b, (i == 7) ? 1 : 0);
         check("gap_01_bv", bv_b, 1);
         check("gap_01_busy", busy_b, 1);
         tick();
      end
      check("gap_words_sent", ws_b, 2);
      check("gap_after_bv", bv_b, 0);

      // LSB-first instance with 8'h01
      do_reset();
      word_in    = 8'h01;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("lsb_d_out", d_c, (i == 0) ? 1 : 0);
         check("lsb_last_bit", lb_c, (i == 7) ? 1 : 0);
         tick();
      end
      check("lsb_words_sent", ws_c, 1);

      // Abort on the 4th bit of 8'hC3
      do_reset();
      exp_w      = 8'hC3;
      word_in    = exp_w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("abort_pre_d", d_a, exp_w[7-i]);
         if (i < 3) tick();
      end
      abort = 1'b1;
      #1 check("abort_ready", ready_a, 0);
      tick();
      abort = 1'b0;
      #1;
      check("abort_bv", bv_a, 0);
      check("abort_d", d_a, 0);
      check("abort_state", st_a, 0);
      check("abort_words_sent", ws_a, 0);
      check("abort_ready_after", ready_a, 1);

      // Abort beats accept in IDLE
      word_valid = 1'b1;
      abort      = 1'b1;
      #1 check("abort_prio_ready", ready_a, 0);
      tick();
      check("abort_prio_busy", busy_a, 0);
      abort = 1'b0;
      tick();
      word_valid = 1'b0;

      // Abort on the last bit drops the word uncounted
      for (int i = 0; i < 7; i++) tick();
      check("abort_last_lb", lb_a, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_last_ws", ws_a, 0);
      check("abort_last_bv", bv_a, 0);

      // Asynchronous reset on the 5th bit of 8'hAA, then 8'h0F
      do_reset();
      exp_w      = 8'hAA;
      word_in    = exp_w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("rmid_d_bit5", d_a, 1);
      check("rmid_bv_bit5", bv_a, 1);
      rst = 1'b0;
      #1;
      check("rmid_d", d_a, 0);
      check("rmid_bv", bv_a, 0);
      check("rmid_busy", busy_a, 0);
      check("rmid_ready", ready_a, 0);
      tick();
      rst = 1'b1;
      tick();
      check("rmid_quiet", bv_a, 0);
      exp_w      = 8'h0F;
      word_in    = exp_w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("r0f_d_out", d_a, exp_w[7-i]);
         tick();
      end
      check("r0f_words_sent", ws_a, 1);

      // 256 back-to-back words wrap words_sent to 0
      do_reset();
      word_in    = 8'h5A;
      word_valid = 1'b1;
      n          = 0;
      budget     = 0;
      while (n < 256 && budget < 3000) begin
         #1;
         if (ready_a) n++;
         tick();
         budget++;
         if (n == 256) word_valid = 1'b0;
      end
      word_valid = 1'b0;
      check("wrap_accepts", n, 256);
      check("wrap_ws_255", ws_a, 255);
      for (int i = 0; i < 8; i++) tick();
      check("wrap_ws_0", ws_a, 0);
      check("wrap_busy", busy_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
